// File: rtl/pwm_mode_sequencer.sv
// Steps the PWM driver's 2-bit mode through up to four programmed duty-cycle
// steps, changing mode only on PWM period boundaries.
module pwm_mode_sequencer #(
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int DWELL_W       = 8
) (
  input  logic                 ext_clk_25m,
  input  logic                 ext_rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic [1:0]           step_last,
  input  logic [7:0]           step_modes,
  input  logic [4*DWELL_W-1:0] step_dwells,
  output logic [1:0]           mode,
  output logic                 busy,
  output logic [1:0]           step_idx,
  output logic                 period_tick,
  output logic                 done
);

  // state | meaning
  // IDLE  | driver held off, waiting for start
  // ARM   | start accepted, waiting for the first period boundary
  // RUN   | stepping through the latched step list
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam int                 PCNT_W    = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [PCNT_W-1:0]  PCNT_LAST = PCNT_W'(PERIOD_CYCLES - 1);
  localparam logic [1:0]         MODE_OFF  = 2'b11;
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t               state, state_nxt;
  logic [PCNT_W-1:0]    pcnt;
  logic [DWELL_W-1:0]   dwell_cnt, dwell_nxt;
  logic [1:0]           mode_nxt, idx_nxt;
  logic                 stop_pend, stop_pend_nxt;
  logic                 done_nxt;
  logic                 load_cfg;

  logic [7:0]           sh_modes;
  logic [4*DWELL_W-1:0] sh_dwells;
  logic [1:0]           sh_last;
  logic                 sh_loop;

  logic [1:0]           sel_idx;
  logic [1:0]           sel_mode;
  logic [DWELL_W-1:0]   sel_dwell_raw;
  logic [DWELL_W-1:0]   sel_dwell;

  assign period_tick = (pcnt == PCNT_LAST);
  assign busy        = (state != IDLE);

  // Step to be loaded at the coming boundary: the next one, or step 0 on entry/loop.
  always_comb begin
    sel_idx = 2'd0;
    if (state == RUN && step_idx < sh_last) sel_idx = step_idx + 2'd1;
    sel_mode      = sh_modes[{sel_idx, 1'b0} +: 2];
    sel_dwell_raw = sh_dwells[int'(sel_idx) * DWELL_W +: DWELL_W];
    sel_dwell     = (sel_dwell_raw == '0) ? DWELL_ONE : sel_dwell_raw;
  end

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode;
    idx_nxt       = step_idx;
    dwell_nxt     = dwell_cnt;
    stop_pend_nxt = stop_pend;
    done_nxt      = 1'b0;
    load_cfg      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = ARM;
          load_cfg  = 1'b1;
        end
      end
      ARM: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (period_tick) begin
          state_nxt = RUN;
          mode_nxt  = sel_mode;
          idx_nxt   = sel_idx;
          dwell_nxt = sel_dwell;
        end
      end
      RUN: begin
        if (period_tick) begin
          if (stop || stop_pend) begin
            state_nxt     = IDLE;
            mode_nxt      = MODE_OFF;
            idx_nxt       = 2'd0;
            stop_pend_nxt = 1'b0;
          end else if (dwell_cnt > DWELL_ONE) begin
            dwell_nxt = dwell_cnt - DWELL_ONE;
          end else if (step_idx < sh_last || sh_loop) begin
            mode_nxt  = sel_mode;
            idx_nxt   = sel_idx;
            dwell_nxt = sel_dwell;
          end else begin
            state_nxt = IDLE;
            mode_nxt  = MODE_OFF;
            idx_nxt   = 2'd0;
            done_nxt  = 1'b1;
          end
        end else if (stop) begin
          stop_pend_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        mode_nxt  = MODE_OFF;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) begin
      pcnt      <= '0;
      state     <= IDLE;
      mode      <= MODE_OFF;
      step_idx  <= 2'd0;
      dwell_cnt <= '0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
      sh_modes  <= '0;
      sh_dwells <= '0;
      sh_last   <= 2'd0;
      sh_loop   <= 1'b0;
    end else begin
      pcnt      <= period_tick ? '0 : pcnt + PCNT_W'(1);
      state     <= state_nxt;
      mode      <= mode_nxt;
      step_idx  <= idx_nxt;
      dwell_cnt <= dwell_nxt;
      stop_pend <= stop_pend_nxt;
      done      <= done_nxt;
      if (load_cfg) begin
        sh_modes  <= step_modes;
        sh_dwells <= step_dwells;
        sh_last   <= step_last;
        sh_loop   <= loop_en;
      end
    end
  end

endmodule

// File: tb/tb_pwm_mode_sequencer.sv
// Scoreboard bench for pwm_mode_sequencer: directed sequences push per-cycle
// expectations; a negedge monitor pops and compares them against the outputs.
module tb_pwm_mode_sequencer;
  localparam int PER = 10;
  localparam int DW  = 4;

  logic          ext_clk_25m = 1'b0;
  logic          ext_rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [1:0]    step_last = 2'd0;
  logic [7:0]    step_modes = 8'h00;
  logic [4*DW-1:0] step_dwells = '0;
  logic [1:0]    mode;
  logic          busy;
  logic [1:0]    step_idx;
  logic          period_tick;
  logic          done;

  pwm_mode_sequencer #(.PERIOD_CYCLES(PER), .DWELL_W(DW)) dut (
    .ext_clk_25m(ext_clk_25m),
    .ext_rst(ext_rst),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
    .step_last(step_last),
    .step_modes(step_modes),
    .step_dwells(step_dwells),
    .mode(mode),
    .busy(busy),
    .step_idx(step_idx),
    .period_tick(period_tick),
    .done(done)
  );

  always #5 ext_clk_25m = ~ext_clk_25m;

  int gcyc = 0;
  always @(posedge ext_clk_25m) gcyc <= gcyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [1:0] mode;
    logic       busy;
    logic [1:0] idx;
    logic       done;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   base = 0;

  exp_t e;
  always @(negedge ext_clk_25m) begin
    while (exp_q.size() != 0 && exp_q[0].cyc < gcyc) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e.nm, e.cyc, gcyc);
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == gcyc) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({mode, busy, step_idx, done, period_tick} !== {e.mode, e.busy, e.idx, e.done, e.tick}) begin
        n_fail++;
        $display("FAIL %s cyc+%0d: got mode=%b busy=%b idx=%0d done=%b tick=%b, required mode=%b busy=%b idx=%0d done=%b tick=%b",
                 e.nm, gcyc - base, mode, busy, step_idx, done, period_tick,
                 e.mode, e.busy, e.idx, e.done, e.tick);
      end
    end
  end

  // Push one expectation per cycle a..b relative to origin org; ticks fall on cycles 9, 19, ...
  task automatic exp_range(input int org, input string nm, input int a, input int b,
                           input logic [1:0] m, input logic bz, input logic [1:0] ix,
                           input logic dn);
    exp_t x;
    for (int c = a; c <= b; c++) begin
      x.cyc  = org + c;
      x.nm   = nm;
      x.mode = m;
      x.busy = bz;
      x.idx  = ix;
      x.done = dn;
      x.tick = ((c % PER) == PER - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic do_reset();
    @(posedge ext_clk_25m); #1;
    ext_rst = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    repeat (3) @(posedge ext_clk_25m);
    #1;
    ext_rst = 1'b0;
    base    = gcyc;
  endtask

  task automatic wait_cyc(input int c);
    while (gcyc < base + c) begin
      @(posedge ext_clk_25m); #1;
    end
  endtask

  task automatic pulse_start(input int c);
    wait_cyc(c); start = 1'b1;
    wait_cyc(c + 1); start = 1'b0;
  endtask

  task automatic pulse_stop(input int c);
    wait_cyc(c); stop = 1'b1;
    wait_cyc(c + 1); stop = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge ext_clk_25m);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cfg_loop();
    loop_en     = 1'b1;
    step_last   = 2'd1;
    step_modes  = 8'b0000_1000;
    step_dwells = 16'h0011;
  endtask

  initial begin
    // single pass with mid-run config changes and an ignored start
    loop_en     = 1'b0;
    step_last   = 2'd2;
    step_modes  = 8'b0010_0100;
    step_dwells = 16'h0312;
    do_reset();
    exp_range(base, "single_idle", 0, 3, 2'b11, 1'b0, 2'd0, 1'b0);
    exp_range(base, "single_arm", 4, 9, 2'b11, 1'b1, 2'd0, 1'b0);
    exp_range(base, "single_s0", 10, 29, 2'b00, 1'b1, 2'd0, 1'b0);
    exp_range(base, "single_s1", 30, 39, 2'b01, 1'b1, 2'd1, 1'b0);
    exp_range(base, "single_s2", 40, 69, 2'b10, 1'b1, 2'd2, 1'b0);
    exp_range(base, "single_done", 70, 70, 2'b11, 1'b0, 2'd0, 1'b1);
    exp_range(base, "single_after", 71, 75, 2'b11, 1'b0, 2'd0, 1'b0);
    pulse_start(3);
    wait_cyc(15);
    step_modes  = 8'hFF;
    step_dwells = 16'hFFFF;
    step_last   = 2'd0;
    loop_en     = 1'b1;
    pulse_start(25);
    drain();

    // looping sequence aborted by stop mid-period
    cfg_loop();
    do_reset();
    exp_range(base, "loop_idle", 0, 3, 2'b11, 1'b0, 2'd0, 1'b0);
    exp_range(base, "loop_arm", 4, 9, 2'b11, 1'b1, 2'd0, 1'b0);
    exp_range(base, "loop_a", 10, 19, 2'b00, 1'b1, 2'd0, 1'b0);
    exp_range(base, "loop_b", 20, 29, 2'b10, 1'b1, 2'd1, 1'b0);
    exp_range(base, "loop_c", 30, 39, 2'b00, 1'b1, 2'd0, 1'b0);
    exp_range(base, "loop_d", 40, 49, 2'b10, 1'b1, 2'd1, 1'b0);
    exp_range(base, "loop_stopped", 50, 55, 2'b11, 1'b0, 2'd0, 1'b0);
    pulse_start(3);
    pulse_stop(45);
    drain();

    // stop arriving in the boundary cycle aborts on that same edge
    cfg_loop();
    do_reset();
    exp_range(base, "bstop_idle", 0, 3, 2'b11, 1'b0, 2'd0, 1'b0);
    exp_range(base, "bstop_arm", 4, 9, 2'b11, 1'b1, 2'd0, 1'b0);
    exp_range(base, "bstop_a", 10, 19, 2'b00, 1'b1, 2'd0, 1'b0);
    exp_range(base, "bstop_b", 20, 29, 2'b10, 1'b1, 2'd1, 1'b0);
    exp_range(base, "bstop_idle2", 30, 35, 2'b11, 1'b0, 2'd0, 1'b0);
    pulse_start(3);
    pulse_stop(29);
    drain();

    // start in a boundary cycle waits a full period; dwell 0 lasts one period
    loop_en     = 1'b0;
    step_last   = 2'd1;
    step_modes  = 8'b0000_1001;
    step_dwells = 16'h0010;
    do_reset();
    exp_range(base, "bstart_idle", 0, 9, 2'b11, 1'b0, 2'd0, 1'b0);
    exp_range(base, "bstart_arm", 10, 19, 2'b11, 1'b1, 2'd0, 1'b0);
    exp_range(base, "bstart_s0", 20, 29, 2'b01, 1'b1, 2'd0, 1'b0);
    exp_range(base, "bstart_s1", 30, 39, 2'b10, 1'b1, 2'd1, 1'b0);
    exp_range(base, "bstart_done", 40, 40, 2'b11, 1'b0, 2'd0, 1'b1);
    exp_range(base, "bstart_after", 41, 43, 2'b11, 1'b0, 2'd0, 1'b0);
    pulse_start(9);
    drain();

    // start+stop together in IDLE ignored; stop during ARM returns to IDLE
    cfg_loop();
    do_reset();
    exp_range(base, "ss_idle", 0, 12, 2'b11, 1'b0, 2'd0, 1'b0);
    exp_range(base, "arm_stop_arm", 13, 15, 2'b11, 1'b1, 2'd0, 1'b0);
    exp_range(base, "arm_stop_idle", 16, 30, 2'b11, 1'b0, 2'd0, 1'b0);
    wait_cyc(3);
    start = 1'b1;
    stop  = 1'b1;
    wait_cyc(4);
    start = 1'b0;
    stop  = 1'b0;
    pulse_start(12);
    pulse_stop(15);
    drain();

    // reset mid-run: cycle 36 shows reset values, next tick at cycle 45
    cfg_loop();
    do_reset();
    exp_range(base, "mrst_idle", 0, 3, 2'b11, 1'b0, 2'd0, 1'b0);
    exp_range(base, "mrst_arm", 4, 9, 2'b11, 1'b1, 2'd0, 1'b0);
    exp_range(base, "mrst_a", 10, 19, 2'b00, 1'b1, 2'd0, 1'b0);
    exp_range(base, "mrst_b", 20, 29, 2'b10, 1'b1, 2'd1, 1'b0);
    exp_range(base, "mrst_c", 30, 35, 2'b00, 1'b1, 2'd0, 1'b0);
    exp_range(base + 36, "mrst_after", 0, 20, 2'b11, 1'b0, 2'd0, 1'b0);
    pulse_start(3);
    wait_cyc(35);
    ext_rst = 1'b1;
    wait_cyc(36);
    ext_rst = 1'b0;
    drain();

    repeat (2) @(posedge ext_clk_25m);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
